// File: rtl/acc_cpu_core.sv
// Multicycle accumulator CPU core: FETCH/DECODE/EXEC control, registered {Z,N,C,V} flags,
// conditional branches, HALT, and a ready-handshaked data-memory port.
module acc_cpu_core #(
    parameter int DW   = 8,
    parameter int AW   = 8,
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    input  logic [DW+4:0]   imem_data,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [AW-1:0]   dmem_addr,
    output logic [DW-1:0]   dmem_wdata,
    input  logic [DW-1:0]   dmem_rdata,
    input  logic            dmem_ready,
    output logic [DW-1:0]   acc_out,
    output logic [3:0]      flags_out,
    output logic            halted
);
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEMRD,
        S_MEMWR,
        S_HALT
    } state_t;

    localparam logic [1:0] TYPE_ALU_IMM = 2'b00;
    localparam logic [1:0] TYPE_ALU_MEM = 2'b01;
    localparam logic [1:0] TYPE_STORE   = 2'b10;
    localparam logic [1:0] TYPE_BRANCH  = 2'b11;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_LOAD = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_SHR  = 3'd7;

    localparam logic [2:0] BR_JMP  = 3'd0;
    localparam logic [2:0] BR_JZ   = 3'd1;
    localparam logic [2:0] BR_JNZ  = 3'd2;
    localparam logic [2:0] BR_JN   = 3'd3;
    localparam logic [2:0] BR_JC   = 3'd4;
    localparam logic [2:0] BR_JV   = 3'd5;
    localparam logic [2:0] BR_HALT = 3'd6;

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg;
    logic [DW+4:0]   ir_reg;
    logic [DW-1:0]   acc_reg;
    logic [DW-1:0]   wdr_reg;
    logic [DW-1:0]   rdr_reg;
    logic [AW-1:0]   mar_reg;
    logic [3:0]      flags_reg;

    logic [1:0]      ir_type;
    logic [2:0]      ir_code;
    logic [DW-1:0]   ir_operand;
    logic            flag_z, flag_n, flag_c, flag_v;

    assign ir_type    = ir_reg[DW+4:DW+3];
    assign ir_code    = ir_reg[DW+2:DW];
    assign ir_operand = ir_reg[DW-1:0];
    assign {flag_z, flag_n, flag_c, flag_v} = flags_reg;

    // ALU: the B operand comes from the read-data register only for memory-operand instructions
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_res;
    logic [DW:0]   alu_wide;
    logic          alu_c;
    logic          alu_v;

    assign alu_b = (ir_type == TYPE_ALU_MEM) ? rdr_reg : ir_operand;

    always_comb begin
        alu_wide = '0;
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (ir_code)
            OP_ADD: begin
                alu_wide = {1'b0, acc_reg} + {1'b0, alu_b};
                alu_res  = alu_wide[DW-1:0];
                alu_c    = alu_wide[DW];
                alu_v    = (acc_reg[DW-1] == alu_b[DW-1]) && (alu_res[DW-1] != acc_reg[DW-1]);
            end
            OP_SUB: begin
                alu_wide = {1'b0, acc_reg} - {1'b0, alu_b};
                alu_res  = alu_wide[DW-1:0];
                alu_c    = alu_wide[DW];
                alu_v    = (acc_reg[DW-1] != alu_b[DW-1]) && (alu_res[DW-1] != acc_reg[DW-1]);
            end
            OP_AND:  alu_res = acc_reg & alu_b;
            OP_OR:   alu_res = acc_reg | alu_b;
            OP_XOR:  alu_res = acc_reg ^ alu_b;
            OP_LOAD: alu_res = alu_b;
            OP_SHL: begin
                alu_res = {acc_reg[DW-2:0], 1'b0};
                alu_c   = acc_reg[DW-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, acc_reg[DW-1:1]};
                alu_c   = acc_reg[0];
            end
            default: ;
        endcase
    end

    logic branch_taken;

    always_comb begin
        branch_taken = 1'b0;
        case (ir_code)
            BR_JMP:  branch_taken = 1'b1;
            BR_JZ:   branch_taken = flag_z;
            BR_JNZ:  branch_taken = !flag_z;
            BR_JN:   branch_taken = flag_n;
            BR_JC:   branch_taken = flag_c;
            BR_JV:   branch_taken = flag_v;
            default: branch_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (ir_type)
                    TYPE_ALU_MEM: state_next = S_MEMRD;
                    TYPE_STORE:   state_next = S_MEMWR;
                    TYPE_BRANCH:  state_next = (ir_code == BR_HALT) ? S_HALT : S_EXEC;
                    default:      state_next = S_EXEC;
                endcase
            end
            S_EXEC:   state_next = S_FETCH;
            S_MEMRD:  state_next = dmem_ready ? S_EXEC : S_MEMRD;
            S_MEMWR:  state_next = dmem_ready ? S_FETCH : S_MEMWR;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Address and write data are snapshotted in DECODE so they hold steady through any wait states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg    <= '0;
            ir_reg    <= '0;
            acc_reg   <= '0;
            flags_reg <= '0;
            mar_reg   <= '0;
            wdr_reg   <= '0;
            rdr_reg   <= '0;
        end else begin
            case (state_reg)
                S_FETCH: ir_reg <= imem_data;
                S_DECODE: begin
                    pc_reg  <= pc_reg + PC_ONE;
                    mar_reg <= ir_operand[AW-1:0];
                    wdr_reg <= acc_reg;
                end
                S_MEMRD: begin
                    if (dmem_ready) begin
                        rdr_reg <= dmem_rdata;
                    end
                end
                S_EXEC: begin
                    if (ir_type == TYPE_BRANCH) begin
                        if (branch_taken) begin
                            pc_reg <= ir_operand[PC_W-1:0];
                        end
                    end else begin
                        acc_reg   <= alu_res;
                        flags_reg <= {alu_res == '0, alu_res[DW-1], alu_c, alu_v};
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr  = pc_reg;
    assign dmem_req   = (state_reg == S_MEMRD) || (state_reg == S_MEMWR);
    assign dmem_we    = (state_reg == S_MEMWR);
    assign dmem_addr  = mar_reg;
    assign dmem_wdata = wdr_reg;
    assign acc_out    = acc_reg;
    assign flags_out  = flags_reg;
    assign halted     = (state_reg == S_HALT);

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: an instruction-level reference model predicts per-cycle port behaviour;
// directed programs carry hand-computed final results.
module tb_acc_cpu_core;
    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [PC_W-1:0] imem_addr;
    logic [DW+4:0]   imem_data;
    logic            dmem_req;
    logic            dmem_we;
    logic [AW-1:0]   dmem_addr;
    logic [DW-1:0]   dmem_wdata;
    logic [DW-1:0]   dmem_rdata;
    logic            dmem_ready = 1'b0;
    logic [DW-1:0]   acc_out;
    logic [3:0]      flags_out;
    logic            halted;

    logic [12:0] imem [256];
    logic [7:0]  dmem [256];
    int          stall_cycles = 0;
    int          resp_wait = 0;
    bit          model_active = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          req_cnt = 0;

    // reference model state
    int  m_pc, m_acc, m_k, m_lat, m_maddr, m_wdata;
    bit  mz, mn, mc, mv;
    bit  m_halt, m_mem, m_we, m_was_active;
    int  mdl_mem [256];

    always #5 clk = ~clk;

    assign imem_data  = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    acc_cpu_core #(.DW(DW), .AW(AW), .PC_W(PC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .acc_out    (acc_out),
        .flags_out  (flags_out),
        .halted     (halted)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] ins(input logic [1:0] t, input logic [2:0] c, input logic [7:0] op);
        return {t, c, op};
    endfunction

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Memory responder: raises ready after stall_cycles wait cycles of a held request
    initial begin
        forever begin
            @(negedge clk);
            if (dmem_req && rst_n) begin
                if (resp_wait >= stall_cycles) begin
                    dmem_ready = 1'b1;
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    resp_wait = 0;
                end else begin
                    dmem_ready = 1'b0;
                    resp_wait++;
                end
            end else begin
                dmem_ready = 1'b0;
                resp_wait = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!model_active) req_cnt = 0;
            else if (dmem_req) req_cnt++;
        end
    end

    // Executes one instruction architecturally and records its expected cycle cost and bus access
    task automatic model_step();
        logic [12:0] w;
        int t, c, op, a, b, r, sr, nxt;
        bit tk;
        w  = imem[m_pc[7:0]];
        t  = int'(w[12:11]);
        c  = int'(w[10:8]);
        op = int'(w[7:0]);
        $display("[TB] pc=%02h instr=%04h acc=%02h flags=%b%b%b%b", m_pc, w, m_acc, mz, mn, mc, mv);
        m_mem = 1'b0;
        m_lat = 3;
        a = m_acc;
        r = 0;
        nxt = (m_pc + 1) % 256;
        if (t <= 1) begin
            b = (t == 0) ? op : mdl_mem[op[7:0]];
            if (t == 1) begin
                m_mem = 1'b1; m_we = 1'b0; m_maddr = op; m_lat = 4 + stall_cycles;
            end
            mc = 1'b0;
            mv = 1'b0;
            case (c)
                0: begin r = a + b; mc = (r > 255); sr = sgn(a) + sgn(b); mv = (sr > 127) || (sr < -128); end
                1: begin r = a - b; mc = (a < b);   sr = sgn(a) - sgn(b); mv = (sr > 127) || (sr < -128); end
                2: r = a & b;
                3: r = a | b;
                4: r = a ^ b;
                5: r = b;
                6: begin r = a * 2; mc = (a >= 128); end
                default: begin r = a / 2; mc = (a % 2 == 1); end
            endcase
            r = r & 255;
            m_acc = r;
            mz = (r == 0);
            mn = (r >= 128);
        end else if (t == 2) begin
            m_mem = 1'b1; m_we = 1'b1; m_maddr = op; m_wdata = m_acc;
            mdl_mem[op[7:0]] = m_acc;
            m_lat = 3 + stall_cycles;
        end else begin
            case (c)
                0: tk = 1'b1;
                1: tk = mz;
                2: tk = !mz;
                3: tk = mn;
                4: tk = mc;
                5: tk = mv;
                6: begin m_halt = 1'b1; tk = 1'b0; end
                default: tk = 1'b0;
            endcase
            if (tk) nxt = op;
        end
        m_pc = nxt;
    endtask

    // Per-cycle comparison against the model; cycle 0 of each instruction is its FETCH
    initial begin
        forever begin
            @(negedge clk);
            if (!model_active) begin
                m_was_active = 1'b0;
            end else begin
                if (!m_was_active) begin
                    m_pc = 0; m_acc = 0; {mz, mn, mc, mv} = 4'b0000;
                    m_k = 0; m_lat = 3; m_halt = 1'b0; m_mem = 1'b0; m_we = 1'b0;
                    for (int i = 0; i < 256; i++) mdl_mem[i] = 0;
                    m_was_active = 1'b1;
                end
                if (m_k == 0 && !m_halt) begin
                    check("fetch_pc", int'(imem_addr), m_pc);
                    check("fetch_acc", int'(acc_out), m_acc);
                    check("fetch_flags", int'(flags_out), int'({mz, mn, mc, mv}));
                    check("fetch_halted", int'(halted), 0);
                    check("fetch_req", int'(dmem_req), 0);
                    model_step();
                end else if (m_halt && m_k >= 2) begin
                    check("halt_flag", int'(halted), 1);
                    check("halt_pc", int'(imem_addr), m_pc);
                    check("halt_acc", int'(acc_out), m_acc);
                    check("halt_flags", int'(flags_out), int'({mz, mn, mc, mv}));
                    check("halt_req", int'(dmem_req), 0);
                end else if (m_mem && m_k >= 2 && m_k <= 2 + stall_cycles) begin
                    check("mem_req", int'(dmem_req), 1);
                    check("mem_we", int'(dmem_we), int'(m_we));
                    check("mem_addr", int'(dmem_addr), m_maddr);
                    if (m_we) check("mem_wdata", int'(dmem_wdata), m_wdata);
                end else begin
                    check("idle_req", int'(dmem_req), 0);
                    check("idle_halted", int'(halted), 0);
                end
                m_k++;
                if (!m_halt && m_k == m_lat) m_k = 0;
            end
        end
    end

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = ins(2'b11, 3'b110, 8'h00);
    endtask

    task automatic start_prog(input int stall);
        model_active = 1'b0;
        rst_n = 1'b0;
        stall_cycles = stall;
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        check("rst_pc", int'(imem_addr), 0);
        check("rst_acc", int'(acc_out), 0);
        check("rst_flags", int'(flags_out), 0);
        check("rst_req", int'(dmem_req), 0);
        check("rst_we", int'(dmem_we), 0);
        check("rst_halted", int'(halted), 0);
        rst_n = 1'b1;
        model_active = 1'b1;
    endtask

    task automatic wait_halt(input int bound, output int cyc);
        cyc = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (halted) begin
                cyc = i;
                break;
            end
        end
        check("halt_reached", (cyc >= 0) ? 1 : 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int found;

        // literal ALU only: LOAD #5; ADD #3
        clear_imem();
        imem[0] = ins(2'b00, 3'd5, 8'h05);
        imem[1] = ins(2'b00, 3'd0, 8'h03);
        start_prog(0);
        wait_halt(40, cyc);
        check("p1_halt_cycle", cyc, 8);
        check("p1_acc", int'(acc_out), 8'h08);
        check("p1_flags", int'(flags_out), 4'b0000);
        check("p1_pc", int'(imem_addr), 3);
        check("p1_req_cycles", req_cnt, 0);

        // signed overflow, borrow, store, JV
        clear_imem();
        imem[0] = ins(2'b00, 3'd5, 8'h7F);
        imem[1] = ins(2'b00, 3'd0, 8'h01);
        imem[2] = ins(2'b10, 3'd0, 8'h30);
        imem[3] = ins(2'b11, 3'd5, 8'h06);
        imem[6] = ins(2'b00, 3'd1, 8'h81);
        start_prog(0);
        wait_halt(60, cyc);
        check("p2_halt_cycle", cyc, 17);
        check("p2_acc", int'(acc_out), 8'hFF);
        check("p2_flags", int'(flags_out), 4'b0110);
        check("p2_pc", int'(imem_addr), 8);
        check("p2_mem30", int'(dmem[8'h30]), 8'h80);
        check("p2_req_cycles", req_cnt, 1);

        // memory round trip with 3 wait cycles per access
        clear_imem();
        imem[0] = ins(2'b00, 3'd5, 8'hAA);
        imem[1] = ins(2'b10, 3'd0, 8'h10);
        imem[2] = ins(2'b00, 3'd5, 8'h00);
        imem[3] = ins(2'b01, 3'd0, 8'h10);
        start_prog(3);
        wait_halt(80, cyc);
        check("p3_halt_cycle", cyc, 21);
        check("p3_acc", int'(acc_out), 8'hAA);
        check("p3_flags", int'(flags_out), 4'b0100);
        check("p3_pc", int'(imem_addr), 5);
        check("p3_mem10", int'(dmem[8'h10]), 8'hAA);
        check("p3_req_cycles", req_cnt, 8);

        // JZ taken, JZ not taken, JMP to 0xFF where HALT's increment wraps pc to 0
        clear_imem();
        imem[8'h00] = ins(2'b00, 3'd5, 8'h00);
        imem[8'h01] = ins(2'b11, 3'd1, 8'h20);
        imem[8'h20] = ins(2'b00, 3'd5, 8'h01);
        imem[8'h21] = ins(2'b11, 3'd1, 8'h40);
        imem[8'h22] = ins(2'b11, 3'd0, 8'hFF);
        start_prog(0);
        wait_halt(60, cyc);
        check("p4_halt_cycle", cyc, 17);
        check("p4_pc_wrap", int'(imem_addr), 0);
        check("p4_acc", int'(acc_out), 1);
        check("p4_flags", int'(flags_out), 4'b0000);

        // shifts and logic ops, JC taken
        clear_imem();
        imem[0] = ins(2'b00, 3'd5, 8'h81);
        imem[1] = ins(2'b00, 3'd6, 8'h00);
        imem[2] = ins(2'b00, 3'd7, 8'h00);
        imem[3] = ins(2'b00, 3'd4, 8'hFF);
        imem[4] = ins(2'b00, 3'd2, 8'h0F);
        imem[5] = ins(2'b00, 3'd3, 8'hF0);
        imem[6] = ins(2'b00, 3'd7, 8'h00);
        imem[7] = ins(2'b00, 3'd6, 8'h00);
        imem[8] = ins(2'b00, 3'd6, 8'h00);
        imem[9] = ins(2'b11, 3'd4, 8'h20);
        start_prog(0);
        wait_halt(80, cyc);
        check("p7_acc", int'(acc_out), 8'hFC);
        check("p7_flags", int'(flags_out), 4'b0110);
        check("p7_pc", int'(imem_addr), 8'h21);

        // memory SUB with signed overflow, JN not taken, JNZ taken, 1 wait cycle
        clear_imem();
        imem[0] = ins(2'b00, 3'd5, 8'h50);
        imem[1] = ins(2'b10, 3'd0, 8'h60);
        imem[2] = ins(2'b00, 3'd5, 8'h90);
        imem[3] = ins(2'b01, 3'd1, 8'h60);
        imem[4] = ins(2'b11, 3'd3, 8'h10);
        imem[5] = ins(2'b11, 3'd2, 8'h12);
        start_prog(1);
        wait_halt(80, cyc);
        check("p8_acc", int'(acc_out), 8'h40);
        check("p8_flags", int'(flags_out), 4'b0001);
        check("p8_pc", int'(imem_addr), 8'h13);
        check("p8_mem60", int'(dmem[8'h60]), 8'h50);
        check("p8_req_cycles", req_cnt, 4);

        // HALT freeze then reset
        clear_imem();
        imem[0] = ins(2'b00, 3'd5, 8'h09);
        start_prog(0);
        wait_halt(40, cyc);
        check("p5_halt_cycle", cyc, 5);
        repeat (20) @(negedge clk);
        check("p5_frozen_acc", int'(acc_out), 8'h09);
        check("p5_frozen_pc", int'(imem_addr), 2);
        check("p5_frozen_halted", int'(halted), 1);
        check("p5_req_cycles", req_cnt, 0);
        @(posedge clk);
        #2;
        model_active = 1'b0;
        rst_n = 1'b0;
        #1;
        check("p5_rst_pc", int'(imem_addr), 0);
        check("p5_rst_halted", int'(halted), 0);
        check("p5_rst_acc", int'(acc_out), 0);

        // reset while a store is stalled
        clear_imem();
        imem[0] = ins(2'b00, 3'd5, 8'h3C);
        imem[1] = ins(2'b10, 3'd0, 8'h44);
        start_prog(100);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dmem_req) begin
                found = 1;
                break;
            end
        end
        check("p6_req_seen", found, 1);
        repeat (2) @(posedge clk);
        #2;
        model_active = 1'b0;
        rst_n = 1'b0;
        #1;
        check("p6_rst_req", int'(dmem_req), 0);
        check("p6_rst_we", int'(dmem_we), 0);
        check("p6_rst_acc", int'(acc_out), 0);
        check("p6_rst_flags", int'(flags_out), 0);
        check("p6_rst_pc", int'(imem_addr), 0);
        check("p6_rst_halted", int'(halted), 0);
        @(negedge clk);
        check("p6_mem44_untouched", int'(dmem[8'h44]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
